// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and helpers for the seven-segment scan path
package ssd_pkg;

    typedef enum logic [0:0] {IDLE, SCAN} ssd_state_t;

    localparam int CHAR_W     = 4;
    localparam int MAX_DIGITS = 32;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [4:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/ssd_lzb_mask.sv
// rtl/ssd_lzb_mask.sv - leading-zero blank mask for a packed hex word
module ssd_lzb_mask
    import ssd_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [CHAR_W*DIGITS-1:0] word_i,
    input  logic                     lzb_en_i,
    output logic [DIGITS-1:0]        mask_o
);

    logic zero_above;

    // Walk from the MSB down; a digit blanks only while everything at or above it is zero.
    always_comb begin
        mask_o     = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (word_i[i*CHAR_W +: CHAR_W] == '0);
            mask_o[i]  = lzb_en_i & zero_above & (i != 0);
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - multi-digit seven-segment scanner with pending buffer and graceful stop
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter bit ACTIVE_LOW_EN = 1'b0
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     data_valid,
    input  logic [CHAR_W*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]        dp_in,
    input  logic                     lzb_en,
    output logic                     data_ready,
    input  logic                     scan_tick,
    input  logic                     stop_req,
    output logic [CHAR_W-1:0]        digit_char,
    output logic                     digit_blank,
    output logic                     digit_dp,
    output logic [DIGITS-1:0]        digit_en,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int IW = $clog2(DIGITS);
    localparam int WW = CHAR_W * DIGITS;
    localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] EN_OFF = {DIGITS{ACTIVE_LOW_EN}};

    ssd_state_t        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WW-1:0]     shadow_q, shadow_d, pend_q, pend_d;
    logic [DIGITS-1:0] sdp_q, sdp_d, pdp_q, pdp_d;
    logic [DIGITS-1:0] smask_q, smask_d, pmask_q, pmask_d;
    logic              pend_valid_q, pend_valid_d;
    logic              stop_q, stop_d;

    logic [CHAR_W-1:0] char_d;
    logic              blank_d, dp_d, fd_d, busy_d, ready_d;
    logic [DIGITS-1:0] en_d;
    logic [DIGITS-1:0] in_mask;
    logic              accept;

    // The mask is computed once at accept time and travels with the word.
    ssd_lzb_mask #(.DIGITS(DIGITS)) u_lzb (
        .word_i   (data_in),
        .lzb_en_i (lzb_en),
        .mask_o   (in_mask)
    );

    assign accept = data_valid & data_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        sdp_d        = sdp_q;
        smask_d      = smask_q;
        pend_d       = pend_q;
        pdp_d        = pdp_q;
        pmask_d      = pmask_q;
        pend_valid_d = pend_valid_q;
        stop_d       = stop_q;
        fd_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SCAN;
                    idx_d    = IDX_TOP;
                    shadow_d = data_in;
                    sdp_d    = dp_in;
                    smask_d  = in_mask;
                end
            end
            SCAN: begin
                if (stop_req) stop_d = 1'b1;
                if (accept) begin
                    pend_d       = data_in;
                    pdp_d        = dp_in;
                    pmask_d      = in_mask;
                    pend_valid_d = 1'b1;
                end
                if (scan_tick) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
                        fd_d  = 1'b1;
                        idx_d = IDX_TOP;
                        if (stop_q | stop_req) begin
                            state_d      = IDLE;
                            pend_valid_d = 1'b0;
                            stop_d       = 1'b0;
                        end else if (pend_valid_q) begin
                            shadow_d     = pend_q;
                            sdp_d        = pdp_q;
                            smask_d      = pmask_q;
                            pend_valid_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are formed from next-state so they land on the same edge as the state change.
        busy_d  = (state_d == SCAN);
        ready_d = (state_d == IDLE) | (~pend_valid_d & ~stop_d);
        if (state_d == SCAN) begin
            char_d  = shadow_d[int'(idx_d)*CHAR_W +: CHAR_W];
            blank_d = smask_d[idx_d];
            dp_d    = sdp_d[idx_d];
            en_d    = DIGITS'(onehot(5'(idx_d))) ^ EN_OFF;
        end else begin
            char_d  = '0;
            blank_d = 1'b1;
            dp_d    = 1'b0;
            en_d    = EN_OFF;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            sdp_q        <= '0;
            smask_q      <= '0;
            pend_q       <= '0;
            pdp_q        <= '0;
            pmask_q      <= '0;
            pend_valid_q <= 1'b0;
            stop_q       <= 1'b0;
            digit_char   <= '0;
            digit_blank  <= 1'b1;
            digit_dp     <= 1'b0;
            digit_en     <= EN_OFF;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            data_ready   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            sdp_q        <= sdp_d;
            smask_q      <= smask_d;
            pend_q       <= pend_d;
            pdp_q        <= pdp_d;
            pmask_q      <= pmask_d;
            pend_valid_q <= pend_valid_d;
            stop_q       <= stop_d;
            digit_char   <= char_d;
            digit_blank  <= blank_d;
            digit_dp     <= dp_d;
            digit_en     <= en_d;
            frame_done   <= fd_d;
            busy         <= busy_d;
            data_ready   <= ready_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - directed self-checking bench for ssd_scan_ctrl
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic        lzb_en = 1'b0;
    logic        scan_tick = 1'b0;
    logic        stop_req = 1'b0;
    logic        data_ready, digit_blank, digit_dp, frame_done, busy;
    logic [3:0]  digit_char;
    logic [7:0]  digit_en;

    logic        v4 = 1'b0;
    logic [15:0] d4 = '0;
    logic [3:0]  dp4 = '0;
    logic        t4 = 1'b0;
    logic        r4, bl4, dpo4, fd4, busy4;
    logic [3:0]  c4, en4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.DIGITS(8), .ACTIVE_LOW_EN(1'b0)) dut (
        .clk(clk), .n_rst(n_rst), .data_valid(data_valid), .data_in(data_in),
        .dp_in(dp_in), .lzb_en(lzb_en), .data_ready(data_ready), .scan_tick(scan_tick),
        .stop_req(stop_req), .digit_char(digit_char), .digit_blank(digit_blank),
        .digit_dp(digit_dp), .digit_en(digit_en), .frame_done(frame_done), .busy(busy)
    );

    ssd_scan_ctrl #(.DIGITS(4), .ACTIVE_LOW_EN(1'b1)) dut4 (
        .clk(clk), .n_rst(n_rst), .data_valid(v4), .data_in(d4),
        .dp_in(dp4), .lzb_en(1'b0), .data_ready(r4), .scan_tick(t4),
        .stop_req(1'b0), .digit_char(c4), .digit_blank(bl4),
        .digit_dp(dpo4), .digit_en(en4), .frame_done(fd4), .busy(busy4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        data_valid = 1'b0; scan_tick = 1'b0; stop_req = 1'b0; v4 = 1'b0; t4 = 1'b0;
        n_rst = 1'b0;
        cyc();
        n_rst = 1'b1;
        cyc();
    endtask

    task automatic accept8(input logic [31:0] w, input logic [7:0] dp, input logic lzb);
        data_in = w; dp_in = dp; lzb_en = lzb; data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        cyc();
        n_cmp++;
        if ({digit_char, digit_blank, digit_dp, digit_en, frame_done, busy, data_ready} !== {4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset8 got char=%h blank=%b dp=%b en=%h fd=%b busy=%b rdy=%b", digit_char, digit_blank, digit_dp, digit_en, frame_done, busy, data_ready);
        end
        n_cmp++;
        if ({c4, bl4, dpo4, en4, fd4, busy4, r4} !== {4'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset4 got char=%h blank=%b en=%b busy=%b rdy=%b want en=1111 blank=1", c4, bl4, en4, busy4, r4);
        end
        n_rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic_scan();
        logic [31:0] w;
        logic [7:0]  exp_en;
        int d;
        w = 32'h1234ABCD;
        do_reset();
        accept8(w, 8'h00, 1'b0);
        n_cmp++;
        if (digit_char !== 4'h1 || digit_en !== 8'h80 || busy !== 1'b1 || data_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_first got char=%h en=%h busy=%b rdy=%b want 1 80 1 1", digit_char, digit_en, busy, data_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            scan_tick = 1'b1;
            cyc();
            d = (k == 8) ? 7 : 7 - k;
            exp_en = 8'(1 << d);
            n_cmp++;
            if (digit_char !== w[d*4 +: 4] || digit_en !== exp_en || frame_done !== (k == 8) || digit_blank !== 1'b0) begin
                n_err++;
                $display("FAIL basic_tick%0d got char=%h en=%h fd=%b blank=%b want char=%h en=%h fd=%b", k, digit_char, digit_en, frame_done, digit_blank, w[d*4 +: 4], exp_en, (k == 8));
            end
        end
        scan_tick = 1'b0;
        cyc();
        n_cmp++;
        if (frame_done !== 1'b0 || digit_char !== 4'h1) begin
            n_err++;
            $display("FAIL basic_fd_pulse got fd=%b char=%h want 0 1", frame_done, digit_char);
        end
    endtask

    task automatic test_lzb();
        int d;
        do_reset();
        accept8(32'h000000F0, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            d = 7 - k;
            if (k > 0) begin
                scan_tick = 1'b1;
                cyc();
            end
            n_cmp++;
            if (digit_blank !== (d >= 2) || digit_char !== ((d == 1) ? 4'hF : 4'h0)) begin
                n_err++;
                $display("FAIL lzb_f0_d%0d got blank=%b char=%h want blank=%b char=%h", d, digit_blank, digit_char, (d >= 2), ((d == 1) ? 4'hF : 4'h0));
            end
        end
        scan_tick = 1'b0;
        do_reset();
        accept8(32'h00000000, 8'h04, 1'b1);
        for (int k = 0; k < 8; k++) begin
            d = 7 - k;
            if (k > 0) begin
                scan_tick = 1'b1;
                cyc();
            end
            n_cmp++;
            if (digit_blank !== (d != 0) || digit_dp !== (d == 2) || digit_en !== 8'(1 << d)) begin
                n_err++;
                $display("FAIL lzb_zero_d%0d got blank=%b dp=%b en=%h want blank=%b dp=%b", d, digit_blank, digit_dp, digit_en, (d != 0), (d == 2));
            end
        end
        scan_tick = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        accept8(32'h11111111, 8'h00, 1'b0);
        scan_tick = 1'b1;
        cyc(); cyc();
        scan_tick = 1'b0;
        accept8(32'h22222222, 8'h00, 1'b0);
        n_cmp++;
        if (data_ready !== 1'b0 || digit_char !== 4'h1) begin
            n_err++;
            $display("FAIL b2b_pending got rdy=%b char=%h want 0 1", data_ready, digit_char);
        end
        data_in = 32'h33333333; data_valid = 1'b1; scan_tick = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_cmp++;
            if (data_ready !== 1'b0 || digit_char !== 4'h1 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_hold%0d got rdy=%b char=%h fd=%b want 0 1 0", k, data_ready, digit_char, frame_done);
            end
        end
        data_valid = 1'b0;
        cyc();
        n_cmp++;
        if (frame_done !== 1'b1 || digit_char !== 4'h2 || digit_en !== 8'h80 || data_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_swap got fd=%b char=%h en=%h rdy=%b want 1 2 80 1", frame_done, digit_char, digit_en, data_ready);
        end
        for (int k = 0; k < 7; k++) begin
            cyc();
            n_cmp++;
            if (digit_char !== 4'h2) begin
                n_err++;
                $display("FAIL b2b_frame2_%0d got char=%h want 2", k, digit_char);
            end
        end
        scan_tick = 1'b0;
    endtask

    task automatic test_stop();
        do_reset();
        accept8(32'h87654321, 8'h00, 1'b0);
        scan_tick = 1'b1;
        cyc(); cyc();
        scan_tick = 1'b0;
        stop_req = 1'b1;
        cyc();
        stop_req = 1'b0;
        n_cmp++;
        if (data_ready !== 1'b0 || busy !== 1'b1 || digit_char !== 4'h6) begin
            n_err++;
            $display("FAIL stop_flag got rdy=%b busy=%b char=%h want 0 1 6", data_ready, busy, digit_char);
        end
        scan_tick = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        n_cmp++;
        if (digit_char !== 4'h1 || digit_en !== 8'h01 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stop_idx0 got char=%h en=%h busy=%b want 1 01 1", digit_char, digit_en, busy);
        end
        cyc();
        n_cmp++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || digit_en !== 8'h00 || data_ready !== 1'b1 || digit_blank !== 1'b1) begin
            n_err++;
            $display("FAIL stop_idle got fd=%b busy=%b en=%h rdy=%b blank=%b want 1 0 00 1 1", frame_done, busy, digit_en, data_ready, digit_blank);
        end
        cyc();
        n_cmp++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || digit_en !== 8'h00) begin
            n_err++;
            $display("FAIL stop_stays_idle got fd=%b busy=%b en=%h want 0 0 00", frame_done, busy, digit_en);
        end
        scan_tick = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        accept8(32'hAAAAAAAA, 8'hFF, 1'b0);
        scan_tick = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        scan_tick = 1'b0;
        accept8(32'h55555555, 8'h00, 1'b0);
        n_cmp++;
        if (digit_en !== 8'h08 || data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arst_setup got en=%h rdy=%b want 08 0", digit_en, data_ready);
        end
        #2;
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({digit_char, digit_blank, digit_dp, digit_en, frame_done, busy, data_ready} !== {4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL arst_immediate got char=%h blank=%b dp=%b en=%h busy=%b rdy=%b", digit_char, digit_blank, digit_dp, digit_en, busy, data_ready);
        end
        cyc();
        n_rst = 1'b1;
        scan_tick = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            n_cmp++;
            if (busy !== 1'b0 || digit_en !== 8'h00 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL arst_norescan%0d got busy=%b en=%h fd=%b want 0 00 0", k, busy, digit_en, frame_done);
            end
        end
        scan_tick = 1'b0;
    endtask

    task automatic test_active_low();
        logic [15:0] w;
        logic [3:0]  exp_en;
        int d;
        w = 16'h9A3C;
        do_reset();
        d4 = w; dp4 = 4'b0100; v4 = 1'b1;
        cyc();
        v4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = 3 - k;
            if (k > 0) begin
                t4 = 1'b1;
                cyc();
            end
            exp_en = ~(4'(1 << d));
            n_cmp++;
            if (en4 !== exp_en || dpo4 !== (d == 2) || c4 !== w[d*4 +: 4] || busy4 !== 1'b1) begin
                n_err++;
                $display("FAIL al4_d%0d got en=%b dp=%b char=%h busy=%b want en=%b dp=%b char=%h", d, en4, dpo4, c4, busy4, exp_en, (d == 2), w[d*4 +: 4]);
            end
        end
        cyc();
        n_cmp++;
        if (fd4 !== 1'b1 || en4 !== 4'b0111) begin
            n_err++;
            $display("FAIL al4_wrap got fd=%b en=%b want 1 0111", fd4, en4);
        end
        t4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lzb();
        test_back_to_back();
        test_stop();
        test_async_reset();
        test_active_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
